// File: rtl/srp_result_checker_if.sv
// Kernel-side bundle: shared launch pulse out, per-channel
// completion strobes and results back from the HLS instances.
interface srp_result_checker_if #(
   parameter int CHANNELS = 2,
   parameter int RESULT_W = 2
) ();
   logic                         r_enable;
   logic [CHANNELS-1:0]          w_enable;
   logic [CHANNELS*RESULT_W-1:0] result;

   modport master (
      output r_enable,
      input  w_enable,
      input  result
   );

   modport slave (
      input  r_enable,
      output w_enable,
      output result
   );
endinterface

// File: rtl/srp_result_checker.sv
// Run-and-check harness: launches all kernels with one pulse,
// captures each result on its first w_enable rise, flags mismatches.
module srp_result_checker #(
   parameter int CHANNELS = 2,
   parameter int RESULT_W = 2,
   parameter int TIMEOUT  = 255,
   parameter int CNT_W    = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [CHANNELS*RESULT_W-1:0] expected,
   srp_result_checker_if.master         kif,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [CHANNELS-1:0]          mismatch,
   output logic                         timed_out,
   output logic [CHANNELS*RESULT_W-1:0] captured
);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t                       state, state_d;
   logic [CHANNELS*RESULT_W-1:0] exp_q, exp_d;
   logic [CHANNELS*RESULT_W-1:0] cap_d;
   logic [CHANNELS-1:0]          got, got_d;
   logic [CHANNELS-1:0]          mis_d;
   logic [CHANNELS-1:0]          wen_q;
   logic [CHANNELS-1:0]          rise;
   logic [CNT_W-1:0]             cnt, cnt_d;
   logic                         ren_q, ren_d;
   logic                         busy_d, done_d;
   logic                         pass_d, to_d;

   assign kif.r_enable = ren_q;
   assign rise         = kif.w_enable & ~wen_q;

   always_comb begin
      state_d = state;
      exp_d   = exp_q;
      cap_d   = captured;
      got_d   = got;
      mis_d   = mismatch;
      cnt_d   = cnt;
      pass_d  = pass;
      to_d    = timed_out;
      ren_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state)
         IDLE, DONE: begin
            done_d = (state == DONE);
            if (start) begin
               state_d = LAUNCH;
               exp_d   = expected;
               cap_d   = '0;
               got_d   = '0;
               mis_d   = '0;
               cnt_d   = '0;
               pass_d  = 1'b0;
               to_d    = 1'b0;
               ren_d   = 1'b1;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         LAUNCH: begin
            state_d = WAIT;
            busy_d  = 1'b1;
         end
         WAIT: begin
            busy_d = 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
               if (rise[i] && !got[i]) begin
                  cap_d[i*RESULT_W +: RESULT_W] =
                     kif.result[i*RESULT_W +: RESULT_W];
                  got_d[i] = 1'b1;
                  mis_d[i] =
                     (kif.result[i*RESULT_W +: RESULT_W] !=
                      exp_q[i*RESULT_W +: RESULT_W]);
               end
            end
            if (cnt != CNT_MAX) cnt_d = cnt + 1'b1;
            // A final capture on the timeout edge still counts as a finish
            if (&got_d) begin
               state_d = DONE;
               pass_d  = ~|mis_d;
               to_d    = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_d = DONE;
               pass_d  = 1'b0;
               to_d    = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         exp_q     <= '0;
         captured  <= '0;
         got       <= '0;
         mismatch  <= '0;
         wen_q     <= '0;
         cnt       <= '0;
         ren_q     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         timed_out <= 1'b0;
      end else begin
         state     <= state_d;
         exp_q     <= exp_d;
         captured  <= cap_d;
         got       <= got_d;
         mismatch  <= mis_d;
         wen_q     <= kif.w_enable;
         cnt       <= cnt_d;
         ren_q     <= ren_d;
         busy      <= busy_d;
         done      <= done_d;
         pass      <= pass_d;
         timed_out <= to_d;
      end
   end

endmodule

// File: tb/tb_srp_result_checker.sv
// Directed bench for srp_result_checker with a short watchdog
// (TIMEOUT=16) so the timeout paths are reachable quickly.
module tb_srp_result_checker;

   localparam int CH = 2;
   localparam int RW = 2;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [CH*RW-1:0] expected;
   logic          busy;
   logic          done;
   logic          pass;
   logic [CH-1:0] mismatch;
   logic          timed_out;
   logic [CH*RW-1:0] captured;

   int total = 0;
   int bad   = 0;

   srp_result_checker_if #(.CHANNELS(CH), .RESULT_W(RW)) kif ();

   srp_result_checker #(
      .CHANNELS(CH),
      .RESULT_W(RW),
      .TIMEOUT (16),
      .CNT_W   (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .expected (expected),
      .kif      (kif),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .mismatch (mismatch),
      .timed_out(timed_out),
      .captured (captured)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic launch(input logic [CH*RW-1:0] e);
      expected = e;
      start    = 1'b1;
      step();
      start    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1, "bench hung");
   end

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      expected     = '0;
      kif.w_enable = '0;
      kif.result   = '0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_mis", mismatch, 0);
      chk("rst_to", timed_out, 0);
      chk("rst_cap", captured, 0);
      chk("rst_ren", kif.r_enable, 0);
      step(2);
      rst_n = 1'b1;
      step();

      // Run 1: ch0 returns 2, ch1 returns 3, all match
      launch(4'b1110);
      chk("r1_ren_hi", kif.r_enable, 1);
      chk("r1_busy", busy, 1);
      step();
      chk("r1_ren_lo", kif.r_enable, 0);
      step(2);
      kif.w_enable = 2'b01;
      kif.result   = 4'b0010;
      step();
      chk("r1_cap0", captured, 4'b0010);
      chk("r1_nodone", done, 0);
      step();
      kif.w_enable = 2'b11;
      kif.result   = 4'b1110;
      chk("r1_nodone2", done, 0);
      step();
      chk("r1_done", done, 1);
      chk("r1_pass", pass, 1);
      chk("r1_mis", mismatch, 2'b00);
      chk("r1_cap", captured, 4'b1110);
      chk("r1_busy_lo", busy, 0);
      chk("r1_to", timed_out, 0);
      kif.w_enable = 2'b00;
      step();
      chk("r1_hold", done, 1);

      // Run 2: ch1 returns 1 instead of 3
      launch(4'b1110);
      chk("r2_clr_done", done, 0);
      chk("r2_clr_cap", captured, 0);
      chk("r2_clr_pass", pass, 0);
      step(2);
      kif.w_enable = 2'b01;
      kif.result   = 4'b0010;
      step();
      kif.w_enable = 2'b11;
      kif.result   = 4'b0110;
      step();
      chk("r2_done", done, 1);
      chk("r2_pass", pass, 0);
      chk("r2_mis", mismatch, 2'b10);
      chk("r2_to", timed_out, 0);
      chk("r2_cap", captured, 4'b0110);
      kif.w_enable = 2'b00;
      step();

      // Run 3: ch1 never answers, watchdog fires after 16 WAIT cycles
      launch(4'b1110);
      step();
      kif.w_enable = 2'b01;
      kif.result   = 4'b0010;
      step(15);
      chk("r3_nodone", done, 0);
      chk("r3_busy", busy, 1);
      step();
      chk("r3_done", done, 1);
      chk("r3_to", timed_out, 1);
      chk("r3_pass", pass, 0);
      chk("r3_cap", captured, 4'b0010);
      chk("r3_mis", mismatch, 2'b00);
      kif.w_enable = 2'b00;
      step();

      // Run 4a: both channels complete on the same edge
      launch(4'b1110);
      step(2);
      kif.w_enable = 2'b11;
      kif.result   = 4'b1110;
      step();
      chk("r4a_done", done, 1);
      chk("r4a_pass", pass, 1);
      chk("r4a_cap", captured, 4'b1110);
      kif.result = 4'b0000;
      step();
      chk("r4a_hold_cap", captured, 4'b1110);
      kif.w_enable = 2'b00;
      step();

      // Run 4b: last capture lands on the timeout edge
      launch(4'b1110);
      step();
      kif.w_enable = 2'b10;
      kif.result   = 4'b1100;
      step(15);
      chk("r4b_nodone", done, 0);
      kif.w_enable = 2'b11;
      kif.result   = 4'b1110;
      step();
      chk("r4b_done", done, 1);
      chk("r4b_to", timed_out, 0);
      chk("r4b_pass", pass, 1);
      chk("r4b_cap", captured, 4'b1110);

      // Run 4c: levels still high from run 4b must not capture
      launch(4'b1110);
      step(5);
      chk("r4c_nocap", captured, 0);
      chk("r4c_busy", busy, 1);
      kif.w_enable = 2'b00;
      step();
      kif.w_enable = 2'b11;
      step();
      chk("r4c_done", done, 1);
      chk("r4c_pass", pass, 1);
      kif.w_enable = 2'b00;
      step();

      // Run 5: async reset mid-WAIT, then a clean run
      launch(4'b1110);
      step();
      kif.w_enable = 2'b01;
      kif.result   = 4'b0010;
      step();
      chk("r5_cap0", captured, 4'b0010);
      #2;
      rst_n = 1'b0;
      #1;
      chk("r5_rst_busy", busy, 0);
      chk("r5_rst_cap", captured, 0);
      chk("r5_rst_ren", kif.r_enable, 0);
      chk("r5_rst_done", done, 0);
      kif.w_enable = 2'b00;
      step();
      rst_n = 1'b1;
      step();
      launch(4'b1110);
      step(2);
      kif.w_enable = 2'b11;
      kif.result   = 4'b1110;
      step();
      chk("r5_done", done, 1);
      chk("r5_pass", pass, 1);
      kif.w_enable = 2'b00;
      kif.result   = 4'b0000;
      step();

      // Run 6: restart from a passing DONE, start during WAIT ignored
      launch(4'b0101);
      chk("r6_clr_pass", pass, 0);
      chk("r6_clr_cap", captured, 0);
      chk("r6_clr_mis", mismatch, 0);
      step();
      expected = 4'b1110;
      start    = 1'b1;
      step();
      chk("r6_busy", busy, 1);
      chk("r6_noren", kif.r_enable, 0);
      start        = 1'b0;
      kif.w_enable = 2'b11;
      kif.result   = 4'b0101;
      step();
      chk("r6_done", done, 1);
      chk("r6_pass", pass, 1);
      chk("r6_mis", mismatch, 2'b00);
      chk("r6_cap", captured, 4'b0101);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
